program_counter: RTL and testbench

PROGRAM_COUNTER -- requirements
Module: program_counter

---
 rtl/program_counter.sv | 60 ++++++
 tb/tb_program_counter.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/program_counter.sv
// Program counter: a single 64-bit PC register whose next value is chosen
// by a 2-bit program-select code, plus a combinational PC + 4 output.
module program_counter (
    input  logic [63:0] in,
    input  logic [1:0]  PS,
    input  logic        reset,
    input  logic        clock,
    output logic [63:0] PC,
    output logic [63:0] PC4
);

    // Program-select codes for the next-PC source
    typedef enum logic [1:0] {
        PS_HOLD   = 2'b00,
        PS_INC    = 2'b01,
        PS_OFFSET = 2'b10,
        PS_SCALED = 2'b11
    } psCode_e;

    logic [63:0] pc_q;
    logic [63:0] pc_d;
    logic [63:0] pcPlus4;
    logic [63:0] scaledOffset;
    psCode_e     psSel;

    assign psSel = psCode_e'(PS);

    // Sequential PC + 4 is shared by the increment and both branch forms,
    // and is also the value presented on PC4 without any register stage.
    assign pcPlus4 = pc_q + 64'd4;

    // Word-scaled offset; the two bits shifted out of the top are dropped,
    // so a negative word offset still wraps correctly modulo 2^64.
    assign scaledOffset = {in[61:0], 2'b00};

    // Next-PC selection; all sums wrap modulo 2^64 with carries discarded
    always_comb begin
        pc_d = pc_q;
        unique case (psSel)
            PS_HOLD:   pc_d = pc_q;
            PS_INC:    pc_d = pcPlus4;
            PS_OFFSET: pc_d = pcPlus4 + in;
            PS_SCALED: pc_d = pcPlus4 + scaledOffset;
            default:   pc_d = pc_q;
        endcase
    end

    // PC register; reset wins over every select code and only acts on an edge
    always_ff @(posedge clock) begin
        if (reset) begin
            pc_q <= 64'd0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC  = pc_q;
    assign PC4 = pcPlus4;

endmodule

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter. Each stimulus cycle pushes the
// expected PC into a scoreboard queue; scenario tasks pop and compare after
// the edge has taken effect.
module tb_program_counter;

    logic [63:0] inSig;
    logic [1:0]  psSig;
    logic        resetSig;
    logic        clock;
    logic [63:0] pcOut;
    logic [63:0] pc4Out;

    int checks = 0;
    int errors = 0;

    logic [63:0] modelPc;
    logic [63:0] scoreboard[$];
    logic [63:0] expPc;

    program_counter dut (
        .in    (inSig),
        .PS    (psSig),
        .reset (resetSig),
        .clock (clock),
        .PC    (pcOut),
        .PC4   (pc4Out)
    );

    // Free-running clock, period 10
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Drive one cycle of stimulus at the falling edge, predict the PC that
    // the next rising edge should produce, then wait until just after it.
    task automatic applyStimulus(input logic r, input logic [1:0] ps, input logic [63:0] val);
        @(negedge clock);
        resetSig = r;
        psSig    = ps;
        inSig    = val;
        if (r) begin
            modelPc = 64'd0;
        end else begin
            case (ps)
                2'b00: modelPc = modelPc;
                2'b01: modelPc = modelPc + 64'd4;
                2'b10: modelPc = modelPc + 64'd4 + val;
                default: modelPc = modelPc + 64'd4 + (val << 2);
            endcase
        end
        scoreboard.push_back(modelPc);
        @(posedge clock);
        #1;
    endtask

    // Reset held for two edges with idle inputs; PC must be 0 and PC4 4
    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 2'b00, 64'd0);
            expPc = scoreboard.pop_front();
            checks++;
            if (pcOut !== expPc || pcOut !== 64'd0) begin
                errors++;
                $display("[TB] FAIL reset_pc cycle %0d: got %h expected %h", i, pcOut, 64'd0);
            end
            checks++;
            if (pc4Out !== 64'd4) begin
                errors++;
                $display("[TB] FAIL reset_pc4 cycle %0d: got %h expected %h", i, pc4Out, 64'd4);
            end
        end
    endtask

    // Hold for two edges, then increment twice
    task automatic test_hold_increment();
        logic [1:0] psTab[4] = '{2'b00, 2'b00, 2'b01, 2'b01};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, psTab[i], 64'd10);
            expPc = scoreboard.pop_front();
            checks++;
            if (pcOut !== expPc) begin
                errors++;
                $display("[TB] FAIL hold_inc_pc step %0d: got %h expected %h", i, pcOut, expPc);
            end
            checks++;
            if (pc4Out !== expPc + 64'd4) begin
                errors++;
                $display("[TB] FAIL hold_inc_pc4 step %0d: got %h expected %h", i, pc4Out, expPc + 64'd4);
            end
        end
        checks++;
        if (pcOut !== 64'd8) begin
            errors++;
            $display("[TB] FAIL hold_inc_final: got %h expected %h", pcOut, 64'd8);
        end
    endtask

    // PC=8, PS=10, in=10 -> 22
    task automatic test_offset_branch();
        applyStimulus(1'b0, 2'b10, 64'd10);
        expPc = scoreboard.pop_front();
        checks++;
        if (pcOut !== expPc || pcOut !== 64'd22) begin
            errors++;
            $display("[TB] FAIL offset_branch_pc: got %h expected %h", pcOut, 64'd22);
        end
        checks++;
        if (pc4Out !== 64'd26) begin
            errors++;
            $display("[TB] FAIL offset_branch_pc4: got %h expected %h", pc4Out, 64'd26);
        end
    endtask

    // PC=22, PS=11, in=10 -> 66, then hold
    task automatic test_scaled_branch();
        logic [1:0] psTab[2] = '{2'b11, 2'b00};
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, psTab[i], 64'd10);
            expPc = scoreboard.pop_front();
            checks++;
            if (pcOut !== expPc || pcOut !== 64'd66) begin
                errors++;
                $display("[TB] FAIL scaled_branch step %0d: got %h expected %h", i, pcOut, 64'd66);
            end
        end
    endtask

    // Inputs wiggle between edges; PC must not move until the next edge
    task automatic test_input_glitch();
        psSig = 2'b10;
        inSig = 64'h1234;
        #2;
        checks++;
        if (pcOut !== modelPc) begin
            errors++;
            $display("[TB] FAIL glitch_no_async: got %h expected %h", pcOut, modelPc);
        end
        applyStimulus(1'b0, 2'b00, 64'h5555);
        expPc = scoreboard.pop_front();
        checks++;
        if (pcOut !== expPc) begin
            errors++;
            $display("[TB] FAIL glitch_hold: got %h expected %h", pcOut, expPc);
        end
    endtask

    // Reset mid-operation beats PS=01 and PS=11, then PS resumes
    task automatic test_reset_mid_op();
        logic       rTab[3]  = '{1'b1, 1'b1, 1'b0};
        logic [1:0] psTab[3] = '{2'b01, 2'b11, 2'b01};
        for (int i = 0; i < 3; i++) begin
            applyStimulus(rTab[i], psTab[i], 64'd5);
            expPc = scoreboard.pop_front();
            checks++;
            if (pcOut !== expPc) begin
                errors++;
                $display("[TB] FAIL reset_mid_op step %0d: got %h expected %h", i, pcOut, expPc);
            end
        end
        checks++;
        if (pcOut !== 64'd4) begin
            errors++;
            $display("[TB] FAIL reset_resume: got %h expected %h", pcOut, 64'd4);
        end
    endtask

    // Reach 0xFFFF_FFFF_FFFF_FFFC, then increment wraps to 0
    task automatic test_wrap();
        applyStimulus(1'b1, 2'b00, 64'd0);
        void'(scoreboard.pop_front());
        applyStimulus(1'b0, 2'b10, 64'hFFFF_FFFF_FFFF_FFF8);
        expPc = scoreboard.pop_front();
        checks++;
        if (pcOut !== expPc || pcOut !== 64'hFFFF_FFFF_FFFF_FFFC) begin
            errors++;
            $display("[TB] FAIL wrap_setup: got %h expected %h", pcOut, 64'hFFFF_FFFF_FFFF_FFFC);
        end
        checks++;
        if (pc4Out !== 64'd0) begin
            errors++;
            $display("[TB] FAIL wrap_pc4: got %h expected %h", pc4Out, 64'd0);
        end
        applyStimulus(1'b0, 2'b01, 64'd0);
        expPc = scoreboard.pop_front();
        checks++;
        if (pcOut !== expPc || pcOut !== 64'd0) begin
            errors++;
            $display("[TB] FAIL wrap_inc: got %h expected %h", pcOut, 64'd0);
        end
    endtask

    // PC=0x100 with scaled offset of -1 lands back on 0x100
    task automatic test_negative_offset();
        applyStimulus(1'b0, 2'b10, 64'hFC);
        expPc = scoreboard.pop_front();
        checks++;
        if (pcOut !== expPc || pcOut !== 64'h100) begin
            errors++;
            $display("[TB] FAIL neg_setup: got %h expected %h", pcOut, 64'h100);
        end
        applyStimulus(1'b0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF);
        expPc = scoreboard.pop_front();
        checks++;
        if (pcOut !== expPc || pcOut !== 64'h100) begin
            errors++;
            $display("[TB] FAIL neg_scaled: got %h expected %h", pcOut, 64'h100);
        end
    endtask

    // Random back-to-back cycles against the reference model
    task automatic test_back_to_back();
        logic [63:0] val;
        for (int i = 0; i < 40; i++) begin
            val = {$urandom(), $urandom()};
            applyStimulus(($urandom_range(0, 15) == 0), 2'($urandom_range(0, 3)), val);
            expPc = scoreboard.pop_front();
            checks++;
            if (pcOut !== expPc) begin
                errors++;
                $display("[TB] FAIL back_to_back_pc cycle %0d: got %h expected %h", i, pcOut, expPc);
            end
            checks++;
            if (pc4Out !== expPc + 64'd4) begin
                errors++;
                $display("[TB] FAIL back_to_back_pc4 cycle %0d: got %h expected %h", i, pc4Out, expPc + 64'd4);
            end
        end
    endtask

    // Scenario sequence and summary
    initial begin
        resetSig = 1'b1;
        psSig    = 2'b00;
        inSig    = 64'd0;
        modelPc  = 64'd0;
        test_reset();
        test_hold_increment();
        test_offset_branch();
        test_scaled_branch();
        test_input_glitch();
        test_reset_mid_op();
        test_wrap();
        test_negative_offset();
        test_back_to_back();
        checks++;
        if (scoreboard.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain: got %0d entries expected %0d", scoreboard.size(), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the bench always ends
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got time %0t expected completion", $time);
        $fatal(1, "[TB] timeout");
    end

endmodule
